// File: rtl/sm83_fetch_if.sv
// Bus and decoder-facing signals of the SM83 fetch stage.
// The fetch stage is the master; memory and decoder sit on the slave side.
interface sm83_fetch_if;
   logic [15:0] bus_addr;
   logic        bus_rd;
   logic [7:0]  bus_rdata;
   logic        bus_ack;
   logic [7:0]  instr;
   logic        instr_is_cb;
   logic        instr_valid;
   logic        instr_ready;
   logic        imm_req;
   logic        imm_len;
   logic [15:0] imm_data;
   logic        imm_valid;
   logic        next_req;
   logic        pc_load;
   logic [15:0] pc_load_val;
   logic [15:0] pc;

   modport master (
      output bus_addr, bus_rd, instr, instr_is_cb, instr_valid, imm_data, imm_valid, pc,
      input  bus_rdata, bus_ack, instr_ready, imm_req, imm_len, next_req, pc_load, pc_load_val
   );

   modport slave (
      input  bus_addr, bus_rd, instr, instr_is_cb, instr_valid, imm_data, imm_valid, pc,
      output bus_rdata, bus_ack, instr_ready, imm_req, imm_len, next_req, pc_load, pc_load_val
   );
endinterface

// File: rtl/sm83_fetch.sv
// SM83 instruction fetch: reads opcodes at PC, folds the 0xCB prefix into a flag,
// hands opcodes to the decoder and fetches little-endian immediates on request.
module sm83_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic          clk,
   input logic          rst,
   sm83_fetch_if.master fif
);

   typedef enum logic [2:0] {
      S_RESET,
      S_FETCH_OP,
      S_FETCH_CB,
      S_HOLD,
      S_DECODE,
      S_IMM_LO,
      S_IMM_HI
   } state_t;

   state_t      state;
   logic [15:0] pc;
   logic [7:0]  instr;
   logic        instr_is_cb;
   logic [15:0] imm_data;
   logic        imm_valid;
   logic        imm_len_q;
   logic        bus_rd;
   logic        ack;

   assign bus_rd = (state == S_FETCH_OP) || (state == S_FETCH_CB) ||
                   (state == S_IMM_LO)   || (state == S_IMM_HI);
   // An ack only counts while a read is actually outstanding.
   assign ack    = bus_rd & fif.bus_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_RESET;
         pc          <= RESET_PC;
         instr       <= 8'h00;
         instr_is_cb <= 1'b0;
         imm_data    <= 16'h0000;
         imm_valid   <= 1'b0;
         imm_len_q   <= 1'b0;
      end else begin
         imm_valid <= 1'b0;
         // A redirect drops any coincident ack and any immediate completing this cycle.
         if (fif.pc_load && (state != S_RESET)) begin
            pc    <= fif.pc_load_val;
            state <= S_FETCH_OP;
         end else begin
            case (state)
               S_RESET: state <= S_FETCH_OP;
               S_FETCH_OP: begin
                  if (ack) begin
                     pc <= pc + 16'd1;
                     if (fif.bus_rdata == 8'hCB) begin
                        state <= S_FETCH_CB;
                     end else begin
                        instr       <= fif.bus_rdata;
                        instr_is_cb <= 1'b0;
                        state       <= S_HOLD;
                     end
                  end
               end
               S_FETCH_CB: begin
                  if (ack) begin
                     pc          <= pc + 16'd1;
                     instr       <= fif.bus_rdata;
                     instr_is_cb <= 1'b1;
                     state       <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (fif.instr_ready) state <= S_DECODE;
               end
               S_DECODE: begin
                  if (fif.imm_req) begin
                     imm_len_q <= fif.imm_len;
                     state     <= S_IMM_LO;
                  end else if (fif.next_req) begin
                     state <= S_FETCH_OP;
                  end
               end
               S_IMM_LO: begin
                  if (ack) begin
                     pc       <= pc + 16'd1;
                     imm_data <= {8'h00, fif.bus_rdata};
                     if (imm_len_q) begin
                        state <= S_IMM_HI;
                     end else begin
                        imm_valid <= 1'b1;
                        state     <= S_DECODE;
                     end
                  end
               end
               S_IMM_HI: begin
                  if (ack) begin
                     pc             <= pc + 16'd1;
                     imm_data[15:8] <= fif.bus_rdata;
                     imm_valid      <= 1'b1;
                     state          <= S_DECODE;
                  end
               end
               default: state <= S_RESET;
            endcase
         end
      end
   end

   assign fif.bus_addr    = pc;
   assign fif.bus_rd      = bus_rd;
   assign fif.pc          = pc;
   assign fif.instr       = instr;
   assign fif.instr_is_cb = instr_is_cb;
   assign fif.instr_valid = (state == S_HOLD);
   assign fif.imm_data    = imm_data;
   assign fif.imm_valid   = imm_valid;

endmodule

// File: tb/tb_sm83_fetch.sv
// Bench for sm83_fetch: directed scenarios, then random programs checked against a
// byte-consumption model of the instruction stream.
module tb_sm83_fetch;

   logic clk;
   logic rst;
   sm83_fetch_if fif ();

   sm83_fetch #(.RESET_PC(16'h0000)) dut (
      .clk (clk),
      .rst (rst),
      .fif (fif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  mem [65536];
   logic [15:0] rd_log [$];
   int          checks = 0;
   int          errors = 0;
   int          last_ack_cyc = 0;
   bit          manual = 1'b0;
   bit          force_ack = 1'b0;
   logic [7:0]  force_data = 8'h00;
   bit          rand_wait = 1'b0;
   int unsigned fixed_delay = 0;

   function automatic int unsigned pick_delay();
      return rand_wait ? $urandom_range(0, 3) : fixed_delay;
   endfunction

   // Memory model; acts just after the falling edge so bench decisions made at the edge win.
   initial begin
      int unsigned wait_cnt;
      int unsigned cur_delay;
      wait_cnt      = 0;
      cur_delay     = 0;
      fif.bus_ack   = 1'b0;
      fif.bus_rdata = 8'h00;
      forever begin
         @(negedge clk);
         #1;
         if (manual) begin
            fif.bus_ack   = force_ack;
            fif.bus_rdata = force_data;
            wait_cnt      = 0;
            cur_delay     = pick_delay();
         end else begin
            fif.bus_ack = 1'b0;
            if (fif.bus_rd) begin
               if (wait_cnt >= cur_delay) begin
                  fif.bus_ack   = 1'b1;
                  fif.bus_rdata = mem[fif.bus_addr];
                  rd_log.push_back(fif.bus_addr);
                  last_ack_cyc  = cyc;
                  wait_cnt      = 0;
                  cur_delay     = pick_delay();
               end else begin
                  wait_cnt++;
               end
            end else begin
               wait_cnt = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_sig(input string tag, input bit imm);
      int n;
      n = 0;
      while (((imm ? fif.imm_valid : fif.instr_valid) !== 1'b1) && (n < 64)) begin
         step();
         n++;
      end
      check(tag, 32'(n < 64), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      check("rst_pc", 32'(fif.pc), 32'h0);
      check("rst_bus_rd", 32'(fif.bus_rd), 32'd0);
      check("rst_instr_valid", 32'(fif.instr_valid), 32'd0);
      check("rst_imm_valid", 32'(fif.imm_valid), 32'd0);
      check("rst_instr", 32'(fif.instr), 32'h0);
      check("rst_is_cb", 32'(fif.instr_is_cb), 32'd0);
      check("rst_imm_data", 32'(fif.imm_data), 32'h0);
      rd_log.delete();
      rst = 1'b0;
   endtask

   task automatic accept();
      fif.instr_ready = 1'b1;
      step();
      fif.instr_ready = 1'b0;
   endtask

   task automatic pulse_imm(input bit len, input bit with_next);
      fif.imm_req  = 1'b1;
      fif.imm_len  = len;
      fif.next_req = with_next;
      step();
      fif.imm_req  = 1'b0;
      fif.imm_len  = 1'b0;
      fif.next_req = 1'b0;
   endtask

   task automatic pulse_next();
      fif.next_req = 1'b1;
      step();
      fif.next_req = 1'b0;
   endtask

   task automatic pulse_load(input logic [15:0] val);
      fif.pc_load     = 1'b1;
      fif.pc_load_val = val;
      step();
      fif.pc_load     = 1'b0;
   endtask

   initial begin
      logic [15:0] mpc;
      logic [7:0]  exp_instr;
      bit          exp_cb;
      bit          len;
      logic [15:0] exp_imm;
      int unsigned choice;

      rst             = 1'b1;
      fif.instr_ready = 1'b0;
      fif.imm_req     = 1'b0;
      fif.imm_len     = 1'b0;
      fif.next_req    = 1'b0;
      fif.pc_load     = 1'b0;
      fif.pc_load_val = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

      // Plain opcode after reset
      do_reset();
      wait_sig("t1_valid_timeout", 1'b0);
      check("t1_nreads", 32'(rd_log.size()), 32'd1);
      check("t1_addr", 32'(rd_log[0]), 32'h0000);
      check("t1_instr", 32'(fif.instr), 32'h00);
      check("t1_is_cb", 32'(fif.instr_is_cb), 32'd0);
      check("t1_pc", 32'(fif.pc), 32'h0001);
      check("t1_latency", 32'(cyc - last_ack_cyc), 32'd1);

      // CB-prefixed opcode
      mem[0] = 8'hCB;
      mem[1] = 8'h37;
      do_reset();
      wait_sig("t2_valid_timeout", 1'b0);
      check("t2_nreads", 32'(rd_log.size()), 32'd2);
      check("t2_addr0", 32'(rd_log[0]), 32'h0000);
      check("t2_addr1", 32'(rd_log[1]), 32'h0001);
      check("t2_instr", 32'(fif.instr), 32'h37);
      check("t2_is_cb", 32'(fif.instr_is_cb), 32'd1);
      check("t2_pc", 32'(fif.pc), 32'h0002);
      check("t2_latency", 32'(cyc - last_ack_cyc), 32'd1);

      // Two-byte then one-byte immediate
      mem[0] = 8'h01;
      mem[1] = 8'h34;
      mem[2] = 8'h12;
      mem[3] = 8'h7F;
      do_reset();
      wait_sig("t3_valid_timeout", 1'b0);
      check("t3_instr", 32'(fif.instr), 32'h01);
      accept();
      rd_log.delete();
      pulse_imm(1'b1, 1'b0);
      wait_sig("t3_imm16_timeout", 1'b1);
      check("t3_nreads", 32'(rd_log.size()), 32'd2);
      check("t3_addr0", 32'(rd_log[0]), 32'h0001);
      check("t3_addr1", 32'(rd_log[1]), 32'h0002);
      check("t3_imm16", 32'(fif.imm_data), 32'h1234);
      check("t3_pc16", 32'(fif.pc), 32'h0003);
      check("t3_imm_latency", 32'(cyc - last_ack_cyc), 32'd1);
      step();
      check("t3_imm_pulse", 32'(fif.imm_valid), 32'd0);
      check("t3_imm_hold", 32'(fif.imm_data), 32'h1234);
      pulse_imm(1'b0, 1'b0);
      wait_sig("t3_imm8_timeout", 1'b1);
      check("t3_imm8", 32'(fif.imm_data), 32'h007F);
      check("t3_pc8", 32'(fif.pc), 32'h0004);
      step();
      check("t3_imm8_pulse", 32'(fif.imm_valid), 32'd0);

      // Decoder stalls for 5 cycles
      mem[4] = 8'h3C;
      pulse_next();
      wait_sig("t4_valid_timeout", 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("t4_valid", 32'(fif.instr_valid), 32'd1);
         check("t4_instr", 32'(fif.instr), 32'h3C);
         check("t4_bus_rd", 32'(fif.bus_rd), 32'd0);
         step();
      end
      accept();
      check("t4_accepted", 32'(fif.instr_valid), 32'd0);

      // Redirect during a withheld read, with a coincident ack
      mem[16'h0150] = 8'h21;
      manual        = 1'b1;
      force_ack     = 1'b0;
      fixed_delay   = 3;
      pulse_load(16'h0010);
      step();
      check("t5_bus_rd", 32'(fif.bus_rd), 32'd1);
      check("t5_addr_0010", 32'(fif.bus_addr), 32'h0010);
      fif.pc_load     = 1'b1;
      fif.pc_load_val = 16'h0150;
      force_ack       = 1'b1;
      force_data      = 8'h55;
      step();
      fif.pc_load = 1'b0;
      force_ack   = 1'b0;
      manual      = 1'b0;
      // Three wait states: address must hold for four cycles
      for (int i = 0; i < 4; i++) begin
         check("t6_addr_stable", 32'(fif.bus_addr), 32'h0150);
         check("t6_pc_stable", 32'(fif.pc), 32'h0150);
         check("t6_bus_rd", 32'(fif.bus_rd), 32'd1);
         check("t6_no_valid", 32'(fif.instr_valid), 32'd0);
         step();
      end
      check("t6_valid", 32'(fif.instr_valid), 32'd1);
      check("t6_instr", 32'(fif.instr), 32'h21);
      check("t6_pc_once", 32'(fif.pc), 32'h0151);
      accept();

      // PC wrap
      fixed_delay     = 0;
      mem[16'hFFFF] = 8'h76;
      pulse_load(16'hFFFF);
      wait_sig("t7_valid_timeout", 1'b0);
      check("t7_instr", 32'(fif.instr), 32'h76);
      check("t7_pc_wrap", 32'(fif.pc), 32'h0000);
      accept();

      // Random programs with random wait states
      rand_wait = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         mem[i] = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
      end
      mpc = 16'($urandom);
      pulse_load(mpc);
      for (int n = 0; n < 40; n++) begin
         wait_sig("rnd_valid_timeout", 1'b0);
         if (mem[mpc] == 8'hCB) begin
            exp_instr = mem[16'(mpc + 16'd1)];
            exp_cb    = 1'b1;
            mpc       = mpc + 16'd2;
         end else begin
            exp_instr = mem[mpc];
            exp_cb    = 1'b0;
            mpc       = mpc + 16'd1;
         end
         check("rnd_instr", 32'(fif.instr), 32'(exp_instr));
         check("rnd_is_cb", 32'(fif.instr_is_cb), 32'(exp_cb));
         check("rnd_pc", 32'(fif.pc), 32'(mpc));
         repeat ($urandom_range(0, 2)) begin
            step();
            check("rnd_hold_instr", 32'(fif.instr), 32'(exp_instr));
            check("rnd_hold_bus", 32'(fif.bus_rd), 32'd0);
         end
         accept();
         repeat ($urandom_range(0, 2)) begin
            check("rnd_decode_idle", 32'(fif.bus_rd), 32'd0);
            step();
         end
         choice = $urandom_range(0, 3);
         if (choice == 1 || choice == 2) begin
            len     = 1'($urandom_range(0, 1));
            exp_imm = {8'h00, mem[mpc]};
            mpc     = mpc + 16'd1;
            if (len) begin
               exp_imm[15:8] = mem[mpc];
               mpc           = mpc + 16'd1;
            end
            pulse_imm(len, choice == 2);
            wait_sig("rnd_imm_timeout", 1'b1);
            check("rnd_imm", 32'(fif.imm_data), 32'(exp_imm));
            check("rnd_imm_pc", 32'(fif.pc), 32'(mpc));
            check("rnd_imm_latency", 32'(cyc - last_ack_cyc), 32'd1);
            step();
            check("rnd_imm_pulse", 32'(fif.imm_valid), 32'd0);
         end
         if (choice == 3) begin
            mpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            pulse_load(mpc);
         end else begin
            pulse_next();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
